panel_scan_ctrl: RTL and testbench

Row-scan sequencer for the 32×16 RGB LED panel (1/8 scan, two half-panels driven in parallel). It fetches pixels from a frame source through an address/data read port, shifts one row pair per scan slot, latches it, and displays it for a programmable on-time. It also samples the game mode only at frame boundaries, so the single- and multi-player frame sources can be swapped without tearing. It replaces the per-mode display interfaces and drives the panel pins directly.

---
 rtl/panel_pkg.sv | 17 +
 rtl/panel_col_shifter.sv | 58 +++++
 rtl/panel_scan_ctrl.sv | 168 ++++++++++++++++
 tb/tb_panel_scan_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// Shared types and constants for the LED panel row-scan controller.
package panel_pkg;

  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DISPLAY, BLANK} scan_state_t;

  localparam int PANEL_COLS      = 32;
  localparam int PANEL_ROW_PAIRS = 8;

  // Bit positions of each colour inside pix_rgb / rgb.
  localparam int RGB_R1 = 5;
  localparam int RGB_G1 = 4;
  localparam int RGB_B1 = 3;
  localparam int RGB_R2 = 2;
  localparam int RGB_G2 = 1;
  localparam int RGB_B2 = 0;

endpackage

// File: rtl/panel_col_shifter.sv
// Column shifter for one row pair: walks the columns in 2-cycle slots, fetches
// pixels and drives rgb/outclk; one trailing slot clocks out the last column.
module panel_col_shifter
  import panel_pkg::*;
#(
  parameter int COLS  = PANEL_COLS,
  parameter int ROW_W = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ROW_W-1:0]                 row,
  input  logic [5:0]                       pix_rgb,
  output logic                             done,
  output logic [ROW_W+$clog2(COLS)-1:0]    pix_addr,
  output logic [5:0]                       rgb,
  output logic                             outclk
);

  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = COL_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COLS);

  logic [CNT_W-1:0] col;
  logic             phase;
  logic             busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col    <= '0;
      phase  <= 1'b0;
      busy   <= 1'b0;
      rgb    <= '0;
      outclk <= 1'b0;
    end else if (start) begin
      col    <= '0;
      phase  <= 1'b0;
      busy   <= 1'b1;
      outclk <= 1'b0;
    end else if (busy) begin
      if (!phase) begin
        phase  <= 1'b1;
        // Slot 0 has no previous column to clock, so no edge there.
        outclk <= (col != '0);
      end else begin
        phase  <= 1'b0;
        outclk <= 1'b0;
        if (col < LAST) rgb <= pix_rgb;
        if (col == LAST) busy <= 1'b0;
        else             col  <= col + 1'b1;
      end
    end
  end

  assign done     = busy && phase && (col == LAST);
  assign pix_addr = {row, col[COL_W-1:0]};

endmodule

// File: rtl/panel_scan_ctrl.sv
// Row-scan sequencer for the 32x16 1/8-scan RGB panel: shift, latch, display, blank.
// Optional PANEL_BRIGHT_EN adds a 4-bit bright input that trims the lit part of DISPLAY.
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROW_PAIRS = PANEL_ROW_PAIRS,
  parameter int ON_CYC    = 256,
  parameter int BLANK_CYC = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
`ifdef PANEL_BRIGHT_EN
  input  logic [3:0]                                 bright,
`endif
  input  logic                                       en,
  input  logic                                       mode,
  output logic                                       mode_sel,
  output logic [$clog2(ROW_PAIRS)+$clog2(COLS)-1:0]  pix_addr,
  input  logic [5:0]                                 pix_rgb,
  output logic [5:0]                                 rgb,
  output logic                                       outclk,
  output logic                                       lat,
  output logic                                       oe,
  output logic [$clog2(ROW_PAIRS)-1:0]               abc,
  output logic                                       frame_start
);

  localparam int ROW_W = $clog2(ROW_PAIRS);
  localparam int MAXD  = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int DW    = $clog2(MAXD + 1);
  localparam logic [DW-1:0]    ON_LAST    = DW'(ON_CYC - 1);
  localparam logic [DW-1:0]    BLANK_LAST = DW'(BLANK_CYC - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROW_PAIRS - 1);

  scan_state_t      state, state_d;
  logic [ROW_W-1:0] row, row_d, abc_d;
  logic [DW-1:0]    dwell, dwell_d;
  logic             lat_d, oe_d, frame_start_d, mode_sel_d;
  logic             shift_start, shift_done;

`ifdef PANEL_BRIGHT_EN
  logic [3:0]    bright_q;
  logic [DW-1:0] on_len;

  function automatic logic [DW-1:0] on_cycles(input logic [3:0] b);
    int unsigned n;
    n = ((int'(b) + 1) * ON_CYC) / 16;
    return DW'(n);
  endfunction

  // The first DISPLAY cycle is decided during LATCH, before bright_q is loaded.
  assign on_len = on_cycles((state == LATCH) ? bright : bright_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               bright_q <= '0;
    else if (state == LATCH) bright_q <= bright;
  end
`endif

  panel_col_shifter #(
    .COLS  (COLS),
    .ROW_W (ROW_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .start    (shift_start),
    .row      (row),
    .pix_rgb  (pix_rgb),
    .done     (shift_done),
    .pix_addr (pix_addr),
    .rgb      (rgb),
    .outclk   (outclk)
  );

  always_comb begin
    state_d       = state;
    row_d         = row;
    dwell_d       = dwell;
    abc_d         = abc;
    lat_d         = 1'b0;
    oe_d          = 1'b1;
    frame_start_d = 1'b0;
    mode_sel_d    = mode_sel;
    shift_start   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_d       = SHIFT;
          row_d         = '0;
          shift_start   = 1'b1;
          frame_start_d = 1'b1;
          mode_sel_d    = mode;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = LATCH;
          lat_d   = 1'b1;
          abc_d   = row;
        end
      end
      LATCH: begin
        state_d = DISPLAY;
        dwell_d = '0;
      end
      DISPLAY: begin
        if (dwell == ON_LAST) begin
          state_d = BLANK;
          dwell_d = '0;
        end else begin
          dwell_d = dwell + 1'b1;
        end
      end
      BLANK: begin
        if (dwell == BLANK_LAST) begin
          dwell_d = '0;
          if (en) begin
            state_d     = SHIFT;
            shift_start = 1'b1;
            row_d       = (row == ROW_LAST) ? '0 : row + 1'b1;
            // Mode only switches between frames so sources never tear.
            if (row == ROW_LAST) begin
              frame_start_d = 1'b1;
              mode_sel_d    = mode;
            end
          end else begin
            state_d = IDLE;
            row_d   = '0;
          end
        end else begin
          dwell_d = dwell + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DISPLAY) begin
`ifdef PANEL_BRIGHT_EN
      oe_d = (dwell_d >= on_len);
`else
      oe_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row         <= '0;
      dwell       <= '0;
      abc         <= '0;
      lat         <= 1'b0;
      oe          <= 1'b1;
      frame_start <= 1'b0;
      mode_sel    <= 1'b0;
    end else begin
      state       <= state_d;
      row         <= row_d;
      dwell       <= dwell_d;
      abc         <= abc_d;
      lat         <= lat_d;
      oe          <= oe_d;
      frame_start <= frame_start_d;
      mode_sel    <= mode_sel_d;
    end
  end

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Directed bench for panel_scan_ctrl with a one-cycle-latency frame source model.
module tb_panel_scan_ctrl;

`ifdef PANEL_BRIGHT_EN
  localparam int ON_EXP = 64;
`else
  localparam int ON_EXP = 256;
`endif
  localparam int SLOT = 327;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic       mode_sel;
  logic [7:0] pix_addr;
  logic [5:0] pix_rgb = '0;
  logic [5:0] rgb;
  logic       outclk, lat, oe, frame_start;
  logic [2:0] abc;
`ifdef PANEL_BRIGHT_EN
  logic [3:0] bright = 4'd3;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int tb_row = 0;
  int edge_idx = 0;
  int oe_low_cnt = 0;
  int last_lat = -1;
  logic outclk_prev = 1'b0;
  logic oe_prev = 1'b1;
  logic mode_sel_prev = 1'b0;
  logic [2:0] abc_prev = '0;

  panel_scan_ctrl dut (
    .clk         (clk),
    .reset       (reset),
`ifdef PANEL_BRIGHT_EN
    .bright      (bright),
`endif
    .en          (en),
    .mode        (mode),
    .mode_sel    (mode_sel),
    .pix_addr    (pix_addr),
    .pix_rgb     (pix_rgb),
    .rgb         (rgb),
    .outclk      (outclk),
    .lat         (lat),
    .oe          (oe),
    .abc         (abc),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Frame source: returns the low address bits one cycle after the address.
  always @(posedge clk) pix_rgb <= pix_addr[5:0];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task observe();
    if (frame_start) begin
      tb_row   = 0;
      edge_idx = 0;
    end
    if (outclk && !outclk_prev) begin
      chk("shift_data", int'(rgb), ((tb_row & 1) << 5) | edge_idx);
      edge_idx++;
    end
    if (abc != abc_prev) chk("abc_only_in_latch", int'({lat, oe}), 3);
    if (mode_sel != mode_sel_prev) chk("mode_sel_with_fs", int'(frame_start), 1);
    if (!oe) oe_low_cnt++;
    if (oe && !oe_prev) begin
      chk("oe_low_cycles", oe_low_cnt, ON_EXP);
      oe_low_cnt = 0;
    end
    if (lat) begin
      chk("edges_per_row", edge_idx, 32);
      chk("abc_seq", int'(abc), tb_row);
      if (last_lat >= 0) chk("row_slot", cyc - last_lat, SLOT);
      last_lat = cyc;
      tb_row++;
      edge_idx = 0;
    end
    outclk_prev   = outclk;
    oe_prev       = oe;
    mode_sel_prev = mode_sel;
    abc_prev      = abc;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_outclk", int'(outclk), 0);
    chk("rst_lat", int'(lat), 0);
    chk("rst_oe", int'(oe), 1);
    chk("rst_abc", int'(abc), 0);
    chk("rst_pix_addr", int'(pix_addr), 0);
    chk("rst_mode_sel", int'(mode_sel), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    reset = 1'b0;
    cyc = -1;

    while (cyc < 4301) begin
      tick();
      case (cyc)
        0: begin
          chk("fs_c0", int'(frame_start), 1);
          chk("addr_c0", int'(pix_addr), 0);
          chk("oe_c0", int'(oe), 1);
        end
        1: chk("no_edge_slot0", int'(outclk), 0);
        3: begin
          chk("outclk_c3", int'(outclk), 1);
          chk("rgb_c3", int'(rgb), 0);
        end
        65: chk("outclk_c65", int'(outclk), 1);
        66: begin
          chk("lat_c66", int'(lat), 1);
          chk("abc_c66", int'(abc), 0);
          chk("oe_c66", int'(oe), 1);
          chk("outclk_c66", int'(outclk), 0);
        end
        67: begin
          chk("lat_c67", int'(lat), 0);
          chk("oe_c67", int'(oe), 0);
        end
        67 + ON_EXP - 1: chk("oe_last_lit", int'(oe), 0);
        67 + ON_EXP: chk("oe_first_dark", int'(oe), 1);
        326: chk("oe_c326", int'(oe), 1);
        327: begin
          chk("addr_row1", int'(pix_addr), 32);
          chk("fs_c327", int'(frame_start), 0);
        end
        1000: mode = 1'b1;
        2615: chk("mode_sel_hold", int'(mode_sel), 0);
        2616: begin
          chk("fs_frame2", int'(frame_start), 1);
          chk("mode_sel_frame2", int'(mode_sel), 1);
          chk("addr_frame2", int'(pix_addr), 0);
        end
        3700: en = 1'b0;
        3924: begin
          chk("idle_oe", int'(oe), 1);
          chk("idle_lat", int'(lat), 0);
          chk("idle_outclk", int'(outclk), 0);
        end
        3940: mode = 1'b0;
        3950: begin
          chk("idle_oe_late", int'(oe), 1);
          chk("idle_outclk_late", int'(outclk), 0);
          chk("idle_fs", int'(frame_start), 0);
          en = 1'b1;
          last_lat = -1;
        end
        3951: begin
          chk("fs_restart", int'(frame_start), 1);
          chk("mode_sel_restart", int'(mode_sel), 0);
          chk("addr_restart", int'(pix_addr), 0);
        end
        4017: begin
          chk("lat_restart", int'(lat), 1);
          chk("abc_restart", int'(abc), 0);
        end
        4301: begin
          chk("pre_rst_outclk", int'(outclk), 1);
          chk("pre_rst_rgb", int'(rgb), 42);
        end
        default: ;
      endcase
    end

    reset = 1'b1;
    #1;
    chk("arst_oe", int'(oe), 1);
    chk("arst_lat", int'(lat), 0);
    chk("arst_outclk", int'(outclk), 0);
    chk("arst_rgb", int'(rgb), 0);
    chk("arst_abc", int'(abc), 0);
    chk("arst_fs", int'(frame_start), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
